// File: rtl/conf_copy_engine_if.sv
// AXI3 master bundle used by the copy engine: read/write address, data and
// response channels, with the engine as master and the memory side as slave.
interface conf_copy_engine_if #(
    parameter int DW  = 64,
    parameter int IDW = 6
);
    logic [31:0]     M_AXI_ARADDR;
    logic [3:0]      M_AXI_ARLEN;
    logic [2:0]      M_AXI_ARSIZE;
    logic [1:0]      M_AXI_ARBURST;
    logic [IDW-1:0]  M_AXI_ARID;
    logic            M_AXI_ARVALID;
    logic            M_AXI_ARREADY;
    logic [DW-1:0]   M_AXI_RDATA;
    logic [1:0]      M_AXI_RRESP;
    logic            M_AXI_RLAST;
    logic            M_AXI_RVALID;
    logic            M_AXI_RREADY;
    logic [31:0]     M_AXI_AWADDR;
    logic [3:0]      M_AXI_AWLEN;
    logic [2:0]      M_AXI_AWSIZE;
    logic [1:0]      M_AXI_AWBURST;
    logic [IDW-1:0]  M_AXI_AWID;
    logic            M_AXI_AWVALID;
    logic            M_AXI_AWREADY;
    logic [DW-1:0]   M_AXI_WDATA;
    logic [DW/8-1:0] M_AXI_WSTRB;
    logic            M_AXI_WLAST;
    logic            M_AXI_WVALID;
    logic            M_AXI_WREADY;
    logic [1:0]      M_AXI_BRESP;
    logic            M_AXI_BVALID;
    logic            M_AXI_BREADY;

    modport master (
        output M_AXI_ARADDR, M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST, M_AXI_ARID, M_AXI_ARVALID,
        input  M_AXI_ARREADY,
        input  M_AXI_RDATA, M_AXI_RRESP, M_AXI_RLAST, M_AXI_RVALID,
        output M_AXI_RREADY,
        output M_AXI_AWADDR, M_AXI_AWLEN, M_AXI_AWSIZE, M_AXI_AWBURST, M_AXI_AWID, M_AXI_AWVALID,
        input  M_AXI_AWREADY,
        output M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WLAST, M_AXI_WVALID,
        input  M_AXI_WREADY,
        input  M_AXI_BRESP, M_AXI_BVALID,
        output M_AXI_BREADY
    );

    modport slave (
        input  M_AXI_ARADDR, M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST, M_AXI_ARID, M_AXI_ARVALID,
        output M_AXI_ARREADY,
        output M_AXI_RDATA, M_AXI_RRESP, M_AXI_RLAST, M_AXI_RVALID,
        input  M_AXI_RREADY,
        input  M_AXI_AWADDR, M_AXI_AWLEN, M_AXI_AWSIZE, M_AXI_AWBURST, M_AXI_AWID, M_AXI_AWVALID,
        output M_AXI_AWREADY,
        input  M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WLAST, M_AXI_WVALID,
        output M_AXI_WREADY,
        output M_AXI_BRESP, M_AXI_BVALID,
        input  M_AXI_BREADY
    );
endinterface

// File: rtl/conf_copy_engine.sv
// Memory-to-memory copy engine: reads one 16-beat burst into a local buffer,
// writes it back out, and repeats until the commanded byte count is moved.
module conf_copy_engine #(
    parameter int BURST_BEATS = 16,
    parameter int DW          = 64,
    parameter int IDW         = 6
) (
    input  logic        ACLK,
    input  logic        ARESETN,
    input  logic        CONFIG_VALID,
    output logic        CONFIG_READY,
    input  logic [31:0] CONFIG_CMD,
    input  logic [31:0] CONFIG_SRC,
    input  logic [31:0] CONFIG_DEST,
    input  logic [31:0] CONFIG_LEN,
    output logic        ERR,
    conf_copy_engine_if.master m_axi
);
    localparam int              IW          = $clog2(BURST_BEATS);
    localparam logic [IW-1:0]   LAST_IDX    = IW'(BURST_BEATS - 1);
    localparam logic [31:0]     BURST_BYTES = 32'(BURST_BEATS * DW / 8);

    typedef enum logic [2:0] {IDLE, RADDR, RDATA, WADDR, WDATA, WRESP} state_t;

    state_t          state_reg, state_next;
    logic [IW-1:0]   idx_reg;
    logic [31:0]     src_reg;
    logic [31:0]     dst_reg;
    logic [24:0]     nburst_reg;
    logic            err_reg;
    logic [DW-1:0]   buf_mem [BURST_BEATS];

    logic [24:0]     len_bursts;
    logic            r_end;
    logic            w_end;
    logic            unused_bits;

    assign len_bursts  = CONFIG_LEN[31:7];
    assign r_end       = (idx_reg == LAST_IDX) || m_axi.M_AXI_RLAST;
    assign w_end       = (idx_reg == LAST_IDX);
    assign unused_bits = ^{CONFIG_CMD[31:1], CONFIG_LEN[6:0]};

    always_ff @(posedge ACLK) begin
        if (!ARESETN) state_reg <= IDLE;
        else          state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:  if (CONFIG_VALID && CONFIG_CMD[0] && (len_bursts != '0)) state_next = RADDR;
            RADDR: if (m_axi.M_AXI_ARREADY) state_next = RDATA;
            RDATA: if (m_axi.M_AXI_RVALID && r_end) state_next = WADDR;
            WADDR: if (m_axi.M_AXI_AWREADY) state_next = WDATA;
            WDATA: if (m_axi.M_AXI_WREADY && w_end) state_next = WRESP;
            WRESP: if (m_axi.M_AXI_BVALID) state_next = (nburst_reg == 25'd1) ? IDLE : RADDR;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        CONFIG_READY        = (state_reg == IDLE);
        m_axi.M_AXI_ARVALID = (state_reg == RADDR);
        m_axi.M_AXI_RREADY  = (state_reg == RDATA);
        m_axi.M_AXI_AWVALID = (state_reg == WADDR);
        m_axi.M_AXI_WVALID  = (state_reg == WDATA);
        m_axi.M_AXI_WLAST   = (state_reg == WDATA) && w_end;
        m_axi.M_AXI_BREADY  = (state_reg == WRESP);
    end

    // Burst bookkeeping; the beat index is shared by the read fill and the write drain.
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            idx_reg    <= '0;
            src_reg    <= '0;
            dst_reg    <= '0;
            nburst_reg <= '0;
            err_reg    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: if (CONFIG_VALID) begin
                    src_reg    <= CONFIG_SRC;
                    dst_reg    <= CONFIG_DEST;
                    nburst_reg <= len_bursts;
                    err_reg    <= 1'b0;
                end
                RDATA: if (m_axi.M_AXI_RVALID) begin
                    if (m_axi.M_AXI_RRESP != 2'b00) err_reg <= 1'b1;
                    idx_reg <= r_end ? '0 : idx_reg + 1'b1;
                end
                WDATA: if (m_axi.M_AXI_WREADY) begin
                    idx_reg <= w_end ? '0 : idx_reg + 1'b1;
                end
                WRESP: if (m_axi.M_AXI_BVALID) begin
                    if (m_axi.M_AXI_BRESP != 2'b00) err_reg <= 1'b1;
                    src_reg    <= src_reg + BURST_BYTES;
                    dst_reg    <= dst_reg + BURST_BYTES;
                    nburst_reg <= nburst_reg - 25'd1;
                end
                default: ;
            endcase
        end
    end

    // Buffer has no reset so it maps onto distributed RAM; early RLAST leaves stale entries.
    always_ff @(posedge ACLK) begin
        if ((state_reg == RDATA) && m_axi.M_AXI_RVALID) buf_mem[idx_reg] <= m_axi.M_AXI_RDATA;
    end

    assign ERR                 = err_reg;
    assign m_axi.M_AXI_ARADDR  = src_reg;
    assign m_axi.M_AXI_AWADDR  = dst_reg;
    assign m_axi.M_AXI_WDATA   = buf_mem[idx_reg];
    assign m_axi.M_AXI_ARLEN   = 4'(BURST_BEATS - 1);
    assign m_axi.M_AXI_AWLEN   = 4'(BURST_BEATS - 1);
    assign m_axi.M_AXI_ARSIZE  = 3'($clog2(DW / 8));
    assign m_axi.M_AXI_AWSIZE  = 3'($clog2(DW / 8));
    assign m_axi.M_AXI_ARBURST = 2'b01;
    assign m_axi.M_AXI_AWBURST = 2'b01;
    assign m_axi.M_AXI_ARID    = '0;
    assign m_axi.M_AXI_AWID    = '0;
    assign m_axi.M_AXI_WSTRB   = '1;
endmodule
